// File: rtl/sonic_pkg.sv
// Shared definitions for the ultrasonic ranging controller: state encoding,
// default timing constants and datapath widths.
package sonic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG      = 3'd1,
        ST_WAIT_ECHO = 3'd2,
        ST_MEASURE   = 3'd3,
        ST_COOLDOWN  = 3'd4
    } state_e;

    localparam int TRIG_US      = 10;
    localparam int ECHO_WAIT_US = 30000;
    localparam int MAX_ECHO_US  = 23200;
    localparam int CM_DIV       = 58;
    localparam int COOLDOWN_US  = 60000;
    localparam int DIST_MAX_CM  = 400;

    localparam int US_CNT_W = 16;
    localparam int SUB_W    = 6;
    localparam int DIST_W   = 9;

endpackage

// File: rtl/sonic_sync.sv
// Two-flop synchronizer bringing the raw echo pin into the clk domain.
module sonic_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= d;
            ff2_q <= ff1_q;
        end
    end

    assign q = ff2_q;

endmodule

// File: rtl/sonic_ctrl.sv
// Ultrasonic range sensor controller: fires the trigger, times the echo in
// microseconds and converts it to whole centimetres with saturation.
module sonic_ctrl
    import sonic_pkg::*;
#(
    parameter int TRIG_US      = sonic_pkg::TRIG_US,
    parameter int ECHO_WAIT_US = sonic_pkg::ECHO_WAIT_US,
    parameter int MAX_ECHO_US  = sonic_pkg::MAX_ECHO_US,
    parameter int CM_DIV       = sonic_pkg::CM_DIV,
    parameter int COOLDOWN_US  = sonic_pkg::COOLDOWN_US
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              us_tick,
    input  logic              echo,
    output logic              trig_out,
    output logic              busy,
    output logic              dist_valid,
    output logic [DIST_W-1:0] dist_cm,
    output logic              err_timeout
);

    state_e                state_q, state_d;
    logic [US_CNT_W-1:0]   us_cnt_q, us_cnt_d;
    logic [SUB_W-1:0]      sub_q, sub_d;
    logic [DIST_W-1:0]     acc_q, acc_d;
    logic [DIST_W-1:0]     dist_q, dist_d;
    logic                  trig_q, trig_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  echo_s;
    logic                  echo_d_q;
    logic                  echo_rise;
    logic                  echo_fall;
    logic [US_CNT_W-1:0]   us_cnt_inc;
    logic [SUB_W-1:0]      sub_nx;
    logic [DIST_W-1:0]     acc_nx;

    sonic_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (echo),
        .q   (echo_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            us_cnt_q <= '0;
            sub_q    <= '0;
            acc_q    <= '0;
            dist_q   <= '0;
            trig_q   <= 1'b0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            echo_d_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            us_cnt_q <= us_cnt_d;
            sub_q    <= sub_d;
            acc_q    <= acc_d;
            dist_q   <= dist_d;
            trig_q   <= trig_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            echo_d_q <= echo_s;
        end
    end

    assign echo_rise  = echo_s & ~echo_d_q;
    assign echo_fall  = ~echo_s & echo_d_q;
    assign us_cnt_inc = us_tick ? (us_cnt_q + 1'b1) : us_cnt_q;

    // One-cm step: the sub-counter divides microseconds by CM_DIV.
    always_comb begin
        sub_nx = sub_q + 1'b1;
        acc_nx = acc_q;
        if (sub_q == SUB_W'(CM_DIV - 1)) begin
            sub_nx = '0;
            if (acc_q < DIST_W'(DIST_MAX_CM)) begin
                acc_nx = acc_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        us_cnt_d = us_cnt_q;
        sub_d    = sub_q;
        acc_d    = acc_q;
        dist_d   = dist_q;
        trig_d   = trig_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_TRIG;
                    trig_d   = 1'b1;
                    us_cnt_d = '0;
                end
            end
            ST_TRIG: begin
                us_cnt_d = us_cnt_inc;
                if (us_tick && us_cnt_q == US_CNT_W'(TRIG_US - 1)) begin
                    state_d  = ST_WAIT_ECHO;
                    trig_d   = 1'b0;
                    us_cnt_d = '0;
                end
            end
            ST_WAIT_ECHO: begin
                us_cnt_d = us_cnt_inc;
                if (echo_rise) begin
                    state_d  = ST_MEASURE;
                    us_cnt_d = '0;
                    sub_d    = '0;
                    acc_d    = '0;
                end else if (us_tick && us_cnt_q == US_CNT_W'(ECHO_WAIT_US - 1)) begin
                    state_d  = ST_COOLDOWN;
                    err_d    = 1'b1;
                    us_cnt_d = '0;
                end
            end
            ST_MEASURE: begin
                us_cnt_d = us_cnt_inc;
                // A tick landing on the falling cycle still counts toward the result.
                if (us_tick && (echo_s || echo_fall)) begin
                    sub_d = sub_nx;
                    acc_d = acc_nx;
                end
                if (echo_fall) begin
                    state_d  = ST_COOLDOWN;
                    dist_d   = us_tick ? acc_nx : acc_q;
                    valid_d  = 1'b1;
                    us_cnt_d = '0;
                end else if (us_tick && echo_s && us_cnt_q == US_CNT_W'(MAX_ECHO_US - 1)) begin
                    state_d  = ST_COOLDOWN;
                    err_d    = 1'b1;
                    us_cnt_d = '0;
                end
            end
            ST_COOLDOWN: begin
                us_cnt_d = us_cnt_inc;
                if (us_tick && us_cnt_q == US_CNT_W'(COOLDOWN_US - 1)) begin
                    state_d  = ST_IDLE;
                    us_cnt_d = '0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                trig_d   = 1'b0;
                us_cnt_d = '0;
            end
        endcase
    end

    assign trig_out    = trig_q;
    assign busy        = (state_q != ST_IDLE);
    assign dist_valid  = valid_q;
    assign dist_cm     = dist_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_sonic_ctrl.sv
// Self-checking bench for sonic_ctrl: table of echo widths plus random widths
// against an arithmetic distance model, and hand sequences for timeouts/reset.
`timescale 1ns/1ps
module tb_sonic_ctrl;

    localparam int TRIG   = 10;
    localparam int WAITUS = 3000;
    localparam int MAXUS  = 23200;
    localparam int DIV    = 58;
    localparam int COOL   = 600;
    localparam int DMAX   = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       echo = 1'b0;
    logic       tick_gap = 1'b0;
    logic       gap_phase = 1'b0;
    logic       us_tick;
    logic       trig_out;
    logic       busy;
    logic       dist_valid;
    logic [8:0] dist_cm;
    logic       err_timeout;

    assign us_tick = tick_gap ? gap_phase : 1'b1;

    sonic_ctrl #(
        .TRIG_US      (TRIG),
        .ECHO_WAIT_US (WAITUS),
        .MAX_ECHO_US  (MAXUS),
        .CM_DIV       (DIV),
        .COOLDOWN_US  (COOL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .us_tick     (us_tick),
        .echo        (echo),
        .trig_out    (trig_out),
        .busy        (busy),
        .dist_valid  (dist_valid),
        .dist_cm     (dist_cm),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int overlap_cnt = 0;

    always @(negedge clk) begin
        if (dist_valid) valid_cnt++;
        if (err_timeout) err_cnt++;
        if (dist_valid && err_timeout) overlap_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        int echo_us;
        int exp_valid;
        int exp_err;
        int exp_cm;
    } vec_t;

    vec_t vecs[$];
    int   prev_cm = 0;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Whole centimetres of echo, saturated at the sensor range.
    function automatic vec_t model(input int n_us);
        vec_t v;
        v.echo_us   = n_us;
        v.exp_valid = (n_us <= MAXUS) ? 1 : 0;
        v.exp_err   = (n_us <= MAXUS) ? 0 : 1;
        v.exp_cm    = (n_us / DIV > DMAX) ? DMAX : n_us / DIV;
        return v;
    endfunction

    task automatic run_meas(input int n_us, input bit poke,
                            output int trig_hi, output int v_cnt,
                            output int e_cnt, output int cm);
        int k;
        valid_cnt = 0;
        err_cnt   = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        trig_hi = 0;
        while (trig_out && trig_hi < TRIG + 20) begin
            trig_hi++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        echo = 1'b1;
        for (int i = 0; i < n_us; i++) begin
            @(negedge clk);
            start = (poke && i == n_us / 2) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        echo  = 1'b0;
        k = 0;
        while (!dist_valid && !err_timeout && k < 100) begin
            @(negedge clk);
            k++;
        end
        cm = dist_cm;
        if (poke) begin
            @(negedge clk) start = 1'b1;
            @(negedge clk) start = 1'b0;
        end
        k = 0;
        while (busy && k < COOL + 50) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        v_cnt = valid_cnt;
        e_cnt = err_cnt;
    endtask

    int trig_hi, v_cnt, e_cnt, cm, n, m;

    initial begin
        // Reset state
        #2;
        check("rst_trig", trig_out, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", dist_valid, 0);
        check("rst_err", err_timeout, 0);
        check("rst_dist", dist_cm, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        vecs.push_back(model(580));
        vecs.push_back(model(57));
        vecs.push_back(model(58));
        vecs.push_back(model(1));
        vecs.push_back(model(116));
        vecs.push_back(model(23199));
        for (int i = 0; i < 8; i++) vecs.push_back(model($urandom_range(1500, 1)));

        foreach (vecs[i]) begin
            run_meas(vecs[i].echo_us, 1'b0, trig_hi, v_cnt, e_cnt, cm);
            $display("meas echo_us=%0d trig_ticks=%0d valid=%0d err=%0d cm=%0d exp_cm=%0d",
                     vecs[i].echo_us, trig_hi, v_cnt, e_cnt, cm, vecs[i].exp_cm);
            check("trig_width", trig_hi, TRIG);
            check("valid_pulses", v_cnt, vecs[i].exp_valid);
            check("err_pulses", e_cnt, vecs[i].exp_err);
            check("dist_cm", cm, vecs[i].exp_valid ? vecs[i].exp_cm : prev_cm);
            if (vecs[i].exp_valid) prev_cm = vecs[i].exp_cm;
        end

        // Stuck echo: timeout fires after MAXUS ticks of synchronized echo
        valid_cnt = 0;
        err_cnt   = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (trig_out && n < TRIG + 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        echo = 1'b1;
        n = 0;
        while (!err_timeout && !dist_valid && n < MAXUS + 50) begin @(negedge clk); n++; end
        echo = 1'b0;
        m = 0;
        while (busy && m < COOL + 50) begin @(negedge clk); m++; end
        repeat (3) @(negedge clk);
        $display("stuck cycles=%0d valid=%0d err=%0d cm=%0d", n, valid_cnt, err_cnt, dist_cm);
        check("stuck_latency", n, MAXUS + 3);
        check("stuck_err", err_cnt, 1);
        check("stuck_valid", valid_cnt, 0);
        check("stuck_dist_kept", dist_cm, prev_cm);

        // Start during MEASURE and COOLDOWN is ignored
        run_meas(580, 1'b1, trig_hi, v_cnt, e_cnt, cm);
        $display("poke echo_us=580 valid=%0d err=%0d cm=%0d busy=%0d", v_cnt, e_cnt, cm, busy);
        check("poke_valid", v_cnt, 1);
        check("poke_cm", cm, 10);
        prev_cm = 10;
        check("poke_idle", busy, 0);
        check("poke_trig", trig_out, 0);

        // No echo: timeout, then full cooldown
        valid_cnt = 0;
        err_cnt   = 0;
        @(negedge clk) start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            if (n == 0) start = 1'b0;
            n++;
        end while (!err_timeout && n < WAITUS + 100);
        m = 0;
        while (busy && m < COOL + 50) begin @(negedge clk); m++; end
        $display("noecho err_after=%0d cooldown=%0d busy=%0d", n, m, busy);
        check("noecho_latency", n, WAITUS + TRIG + 1);
        check("noecho_cooldown", m, COOL);
        check("noecho_busy", busy, 0);
        check("noecho_valid", valid_cnt, 0);

        // Sparse ticks: trigger width counts ticks, not clocks
        tick_gap = 1'b1;
        gap_phase = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        gap_phase = 1'b1;
        n = trig_out ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (trig_out) n++;
            gap_phase = ~gap_phase;
        end
        $display("gap trig_clocks=%0d busy=%0d", n, busy);
        check("gap_trig_clocks", n, 2 * TRIG - 1);
        valid_cnt = 0;
        err_cnt   = 0;
        #2 rst = 1'b1;
        #1;
        check("wait_rst_busy", busy, 0);
        @(negedge clk) rst = 1'b0;
        tick_gap = 1'b0;
        repeat (3) @(negedge clk);
        check("wait_rst_nopulse", valid_cnt + err_cnt, 0);

        // Reset during TRIG drops everything without a clock edge
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (2) @(negedge clk);
        check("trig_before_rst", trig_out, 1);
        valid_cnt = 0;
        err_cnt   = 0;
        #2 rst = 1'b1;
        #1;
        $display("rst_in_trig trig=%0d busy=%0d cm=%0d", trig_out, busy, dist_cm);
        check("rst_trig_async", trig_out, 0);
        check("rst_busy_async", busy, 0);
        check("rst_dist_async", dist_cm, 0);
        check("rst_valid_async", dist_valid, 0);
        check("rst_err_async", err_timeout, 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_nopulse", valid_cnt + err_cnt, 0);
        check("rst_idle", busy, 0);

        // Recovery after reset
        run_meas(116, 1'b0, trig_hi, v_cnt, e_cnt, cm);
        $display("recover echo_us=116 valid=%0d cm=%0d", v_cnt, cm);
        check("recover_valid", v_cnt, 1);
        check("recover_cm", cm, 2);

        check("no_overlap", overlap_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
